// File: rtl/uc_sched.sv
// uc_sched: unit-clause scheduler. Streams the initial unit clauses from memory,
// then drains the propagation engines' output FIFOs round-robin and broadcasts
// one literal per cycle. Detects quiescence (done) and latches conflicts.
module uc_sched #(
  parameter int unsigned NUM_ENGINE  = 4,
  parameter int unsigned LIT_IDX_MAX = 127,
  parameter int unsigned LIT_W       = $clog2(LIT_IDX_MAX) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          mem_valid,
  input  logic [LIT_W-1:0]              mem_lit,
  input  logic                          mem_done,
  output logic                          mem_ready,
  input  logic [NUM_ENGINE-1:0]         eng_empty,
  input  logic [NUM_ENGINE*LIT_W-1:0]   eng_lit,
  output logic [NUM_ENGINE-1:0]         eng_rd,
  input  logic [NUM_ENGINE-1:0]         eng_full,
  input  logic [NUM_ENGINE-1:0]         eng_idle,
  input  logic                          conflict_in,
  output logic                          bcast_valid,
  output logic [LIT_W-1:0]              bcast_lit,
  output logic [NUM_ENGINE-1:0]         engmask,
  output logic                          done,
  output logic                          conflict
);

  localparam int unsigned IDX_W  = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam int unsigned QCNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_CONFLICT
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    ptr_nxt;
  logic [QCNT_W-1:0]   qcnt;
  logic [QCNT_W-1:0]   qcnt_nxt;

  logic                stall;
  logic                quiet;
  logic                restart;
  logic                accept;
  logic                pop;
  logic                grant_vld;
  logic [IDX_W-1:0]    grant;
  logic [IDX_W-1:0]    cand;
  logic [LIT_W-1:0]    grant_lit;
  logic [NUM_ENGINE-1:0] grant_oh;

  logic                bv_nxt;
  logic [LIT_W-1:0]    bl_nxt;
  logic [NUM_ENGINE-1:0] em_nxt;

  // Backpressure and quiescence qualifiers
  always_comb begin
    stall   = |eng_full;
    quiet   = (&eng_empty) && (&eng_idle) && !bcast_valid;
    restart = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_CONFLICT));
  end

  // Round-robin search: first non-empty engine at or after the pointer, with wrap
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_ENGINE; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_ENGINE);
      if (!grant_vld && !eng_empty[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  // Head literal and one-hot of the granted engine
  always_comb begin
    grant_lit = '0;
    grant_oh  = '0;
    for (int unsigned i = 0; i < NUM_ENGINE; i++) begin
      if (grant == IDX_W'(i)) begin
        grant_lit   = eng_lit[i*LIT_W +: LIT_W];
        grant_oh[i] = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; conflict outranks quiescence and start is ignored mid-solve
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (conflict_in)               state_nxt = S_CONFLICT;
        else if (mem_done && !accept)  state_nxt = S_RUN;
      end
      S_RUN: begin
        if (conflict_in)                           state_nxt = S_CONFLICT;
        else if (quiet && (qcnt == QCNT_W'(1)))    state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_CONFLICT: begin
        if (start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: combinational handshakes plus next values of the broadcast register
  always_comb begin
    mem_ready = 1'b0;
    accept    = 1'b0;
    pop       = 1'b0;
    eng_rd    = '0;
    bv_nxt    = 1'b0;
    bl_nxt    = '0;
    em_nxt    = '0;
    case (state)
      S_LOAD: begin
        mem_ready = !stall && !conflict_in;
        accept    = mem_valid && mem_ready;
        if (accept && (mem_lit != '0)) begin
          bv_nxt = 1'b1;
          bl_nxt = mem_lit;
          em_nxt = '1;
        end
      end
      S_RUN: begin
        pop = grant_vld && !stall && !conflict_in;
        if (pop) begin
          eng_rd = grant_oh;
          // Zero head literal is discarded without a broadcast
          if (grant_lit != '0) begin
            bv_nxt = 1'b1;
            bl_nxt = grant_lit;
            em_nxt = ~grant_oh;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Pointer and quiet-counter next values
  always_comb begin
    ptr_nxt  = ptr;
    qcnt_nxt = '0;
    if (restart) begin
      ptr_nxt = '0;
    end else if (pop) begin
      ptr_nxt = (32'(grant) == NUM_ENGINE - 1) ? '0 : grant + IDX_W'(1);
    end
    if ((state == S_RUN) && quiet) begin
      qcnt_nxt = (qcnt == QCNT_W'(2)) ? qcnt : qcnt + QCNT_W'(1);
    end
  end

  // Registered broadcast, status and arbitration state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcast_valid <= 1'b0;
      bcast_lit   <= '0;
      engmask     <= '0;
      done        <= 1'b0;
      conflict    <= 1'b0;
      ptr         <= '0;
      qcnt        <= '0;
    end else begin
      bcast_valid <= bv_nxt;
      bcast_lit   <= bl_nxt;
      engmask     <= em_nxt;
      done        <= (state_nxt == S_DONE);
      conflict    <= (state_nxt == S_CONFLICT);
      ptr         <= ptr_nxt;
      qcnt        <= qcnt_nxt;
    end
  end

endmodule

// File: tb/tb_uc_sched.sv
// Directed bench for uc_sched: expected broadcasts go into a scoreboard queue
// when stimulus is issued; a monitor pops and compares on every bcast_valid.
module tb_uc_sched;

  localparam int unsigned NE = 4;
  localparam int unsigned LW = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic              mem_valid;
  logic [LW-1:0]     mem_lit;
  logic              mem_done;
  logic              mem_ready;
  logic [NE-1:0]     eng_empty;
  logic [NE*LW-1:0]  eng_lit;
  logic [NE-1:0]     eng_rd;
  logic [NE-1:0]     eng_full;
  logic [NE-1:0]     eng_idle;
  logic              conflict_in;
  logic              bcast_valid;
  logic [LW-1:0]     bcast_lit;
  logic [NE-1:0]     engmask;
  logic              done;
  logic              conflict;

  int checks = 0;
  int errors = 0;

  logic [11:0] sb [$];
  logic [11:0] mon_exp;
  logic [7:0]  fq [NE][$];

  uc_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_valid  (mem_valid),
    .mem_lit    (mem_lit),
    .mem_done   (mem_done),
    .mem_ready  (mem_ready),
    .eng_empty  (eng_empty),
    .eng_lit    (eng_lit),
    .eng_rd     (eng_rd),
    .eng_full   (eng_full),
    .eng_idle   (eng_idle),
    .conflict_in(conflict_in),
    .bcast_valid(bcast_valid),
    .bcast_lit  (bcast_lit),
    .engmask    (engmask),
    .done       (done),
    .conflict   (conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Monitor: every broadcast must match the oldest expected entry
  always @(negedge clk) begin
    if (rst && bcast_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL bcast_unexpected: got lit %0h mask %b, none expected", bcast_lit, engmask);
      end else begin
        mon_exp = sb.pop_front();
        if ({bcast_lit, engmask} !== mon_exp) begin
          errors++;
          $display("FAIL bcast: got lit %0h mask %b, expected lit %0h mask %b",
                   bcast_lit, engmask, mon_exp[11:4], mon_exp[3:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present engine FIFO heads from the model queues
  task automatic refresh();
    for (int i = 0; i < NE; i++) begin
      eng_empty[i] = (fq[i].size() == 0);
      eng_lit[i*LW +: LW] = (fq[i].size() == 0) ? 8'h00 : fq[i][0];
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Called at a negedge: capture pops, advance to just after the next posedge
  task automatic tick();
    logic [NE-1:0] rd;
    rd = eng_rd;
    @(posedge clk);
    #1;
    for (int i = 0; i < NE; i++) begin
      if (rd[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    end
    refresh();
  endtask

  task automatic mem_send(input logic [7:0] lit);
    mem_valid = 1'b1;
    mem_lit   = lit;
    if (lit != 8'h00) sb.push_back({lit, 4'b1111});
    for (int n = 0; n < 20; n++) begin
      neg();
      if (mem_ready) begin
        tick();
        mem_valid = 1'b0;
        return;
      end
      tick();
    end
    checks++;
    errors++;
    $display("FAIL mem_send_timeout: literal %0h never accepted", lit);
    mem_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_rd;
    rst = 1'b0; start = 1'b0; mem_valid = 1'b0; mem_lit = '0; mem_done = 1'b0;
    eng_full = '0; eng_idle = '1; conflict_in = 1'b0;
    eng_empty = '1; eng_lit = '0;
    refresh();

    // Reset state
    neg();
    chk("rst_bcast_valid", 32'(bcast_valid), 32'd0);
    chk("rst_engmask",     32'(engmask),     32'd0);
    chk("rst_eng_rd",      32'(eng_rd),      32'd0);
    chk("rst_mem_ready",   32'(mem_ready),   32'd0);
    chk("rst_done",        32'(done),        32'd0);
    chk("rst_conflict",    32'(conflict),    32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Memory load with a 3-cycle stall in the middle
    eng_idle = '0;
    start = 1'b1; neg(); tick(); start = 1'b0;
    mem_send(8'd10);
    mem_send(8'd20);
    mem_send(8'd30);
    mem_valid = 1'b1; mem_lit = 8'd40; sb.push_back({8'd40, 4'b1111});
    eng_full = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("load_stall_ready", 32'(mem_ready), 32'd0);
      if (k > 0) chk("load_stall_bv", 32'(bcast_valid), 32'd0);
      tick();
    end
    eng_full = '0;
    neg();
    chk("load_resume_ready", 32'(mem_ready), 32'd1);
    chk("load_resume_bv",    32'(bcast_valid), 32'd0);
    tick();
    mem_valid = 1'b0;
    mem_send(8'd50);
    mem_done = 1'b1;
    neg(); tick();
    mem_done = 1'b0;
    mem_valid = 1'b1; mem_lit = 8'd99;
    neg();
    chk("run_no_mem_ready", 32'(mem_ready), 32'd0);
    tick();
    mem_valid = 1'b0;

    // Round-robin drain from pointer 0
    fq[0].push_back(8'd2); fq[1].push_back(8'd4); fq[2].push_back(8'd3); fq[3].push_back(8'hFE);
    sb.push_back({8'd2, 4'b1110}); sb.push_back({8'd4, 4'b1101});
    sb.push_back({8'd3, 4'b1011}); sb.push_back({8'hFE, 4'b0111});
    refresh();
    for (int k = 0; k < 4; k++) begin
      exp_rd = 4'b0001 << k;
      neg();
      chk("rr_eng_rd", 32'(eng_rd), 32'(exp_rd));
      tick();
    end

    // Stall in RUN, then zero literal from engine 1 and a real one from engine 3
    fq[1].push_back(8'd0); fq[3].push_back(8'd9);
    sb.push_back({8'd9, 4'b0111});
    eng_full = 4'b0100;
    refresh();
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("run_stall_rd", 32'(eng_rd), 32'd0);
      if (k > 0) chk("run_stall_bv", 32'(bcast_valid), 32'd0);
      tick();
    end
    eng_full = '0;
    neg();
    chk("zero_pop_rd", 32'(eng_rd), 32'b0010);
    tick();
    neg();
    chk("zero_no_bcast", 32'(bcast_valid), 32'd0);
    chk("after_zero_rd", 32'(eng_rd), 32'b1000);
    tick();

    // Quiescence: done on the third quiet-condition cycle
    eng_idle = '1;
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("quiet_done_low", 32'(done), 32'd0);
      tick();
    end
    neg();
    chk("quiet_done_high", 32'(done), 32'd1);
    tick();

    // Restart from DONE, straight to RUN, then conflict with a pending engine
    start = 1'b1; neg(); tick(); start = 1'b0;
    mem_done = 1'b1; eng_idle = '0;
    neg();
    chk("restart_done_clr", 32'(done), 32'd0);
    chk("restart_load", 32'(mem_ready), 32'd1);
    tick();
    mem_done = 1'b0;
    fq[2].push_back(8'd5); conflict_in = 1'b1; refresh();
    neg();
    chk("conf_no_pop", 32'(eng_rd), 32'd0);
    chk("conf_not_yet", 32'(conflict), 32'd0);
    tick();
    conflict_in = 1'b0;
    neg();
    chk("conf_set", 32'(conflict), 32'd1);
    chk("conf_no_pop_after", 32'(eng_rd), 32'd0);
    tick();
    fq[2].delete(); eng_idle = '1; refresh();
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("conf_done_low", 32'(done), 32'd0);
      chk("conf_sticky", 32'(conflict), 32'd1);
      tick();
    end
    start = 1'b1; neg(); tick(); start = 1'b0;
    eng_idle = '0;
    neg();
    chk("conf_clr", 32'(conflict), 32'd0);
    chk("conf_restart_load", 32'(mem_ready), 32'd1);
    tick();

    // Load one literal, enter RUN, then reset while a broadcast is out
    mem_send(8'd11);
    mem_done = 1'b1; neg(); tick(); mem_done = 1'b0;
    fq[2].push_back(8'd6); refresh();
    neg();
    chk("pre_rst_rd", 32'(eng_rd), 32'b0100);
    tick();
    fq[1].push_back(8'd8); refresh();
    #1;
    chk("pre_rst_bv",  32'(bcast_valid), 32'd1);
    chk("pre_rst_lit", 32'(bcast_lit),   32'd6);
    chk("pre_rst_rd2", 32'(eng_rd),      32'b0010);
    rst = 1'b0;
    #1;
    chk("mid_rst_bv",      32'(bcast_valid), 32'd0);
    chk("mid_rst_engmask", 32'(engmask),     32'd0);
    chk("mid_rst_rd",      32'(eng_rd),      32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < NE; i++) fq[i].delete();
    refresh();
    rst = 1'b1;
    neg();
    chk("post_rst_idle", 32'(mem_ready), 32'd0);
    tick();

    // After reset the first grant starts at engine 0
    start = 1'b1; neg(); tick(); start = 1'b0;
    mem_send(8'd13);
    mem_done = 1'b1; neg(); tick(); mem_done = 1'b0;
    fq[0].push_back(8'd21); fq[3].push_back(8'd22);
    sb.push_back({8'd21, 4'b1110}); sb.push_back({8'd22, 4'b0111});
    refresh();
    neg();
    chk("post_rst_grant0", 32'(eng_rd), 32'b0001);
    tick();
    neg();
    chk("post_rst_grant3", 32'(eng_rd), 32'b1000);
    tick();
    eng_idle = '1;
    for (int k = 0; k < 3; k++) begin
      neg(); tick();
    end
    neg();
    chk("final_done", 32'(done), 32'd1);
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
